// File: rtl/alu_issue_pkg.sv
// Shared definitions for the ALU issue stage: widths, register index and op-code types,
// the output-stage state encoding and the per-source hazard helper.
package alu_issue_pkg;

  localparam int unsigned ALU_WIDTH = 64;
  localparam int unsigned ALU_NREGS = 32;
  localparam int unsigned REG_IDX_W = 5;
  localparam int unsigned ALU_OP_W  = 4;

  typedef logic [REG_IDX_W-1:0] reg_idx_t;
  typedef logic [ALU_OP_W-1:0]  alu_op_t;

  // Op-code values understood by the downstream ALU; the issue stage never decodes them.
  typedef enum logic [ALU_OP_W-1:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_AND  = 4'd2,
    OP_OR   = 4'd3,
    OP_XOR  = 4'd4,
    OP_SLL  = 4'd5,
    OP_SRL  = 4'd6,
    OP_SRA  = 4'd7,
    OP_SLT  = 4'd8,
    OP_SLTU = 4'd9,
    OP_MOVB = 4'd10
  } alu_op_e;

  typedef enum logic {
    OUT_EMPTY = 1'b0,
    OUT_FULL  = 1'b1
  } out_state_e;

  // A busy source stalls issue unless it is x0 or is being written back this cycle.
  function automatic logic src_hazard(input logic     busy_bit,
                                      input reg_idx_t idx,
                                      input logic     wb_en,
                                      input reg_idx_t wb_rd);
    return busy_bit && (idx != '0) && !(wb_en && (wb_rd == idx));
  endfunction

endpackage

// File: rtl/alu_regfile.sv
// Architectural register file: two combinational read ports with write-first bypass,
// one write port, x0 reads as zero and ignores writes.
module alu_regfile
  import alu_issue_pkg::*;
#(
  parameter int unsigned WIDTH = ALU_WIDTH,
  parameter int unsigned NREGS = ALU_NREGS
) (
  input  logic             clk,
  input  logic             rst,
  input  reg_idx_t         raddr1,
  input  reg_idx_t         raddr2,
  output logic [WIDTH-1:0] rdata1,
  output logic [WIDTH-1:0] rdata2,
  input  logic             we,
  input  reg_idx_t         waddr,
  input  logic [WIDTH-1:0] wdata
);

  logic [WIDTH-1:0] regs [NREGS];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < NREGS; i++) begin
        regs[i] <= '0;
      end
    end else if (we && (waddr != '0)) begin
      regs[waddr] <= wdata;
    end
  end

  always_comb begin
    rdata1 = '0;
    if (raddr1 != '0) begin
      rdata1 = (we && (waddr == raddr1)) ? wdata : regs[raddr1];
    end
  end

  always_comb begin
    rdata2 = '0;
    if (raddr2 != '0) begin
      rdata2 = (we && (waddr == raddr2)) ? wdata : regs[raddr2];
    end
  end

endmodule

// File: rtl/alu_issue.sv
// ALU issue stage: scoreboards destination registers, stalls on RAW hazards, reads
// operands with write-back bypass and presents them through a one-deep output register.
module alu_issue
  import alu_issue_pkg::*;
#(
  parameter int unsigned WIDTH = ALU_WIDTH,
  parameter int unsigned NREGS = ALU_NREGS
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  reg_idx_t            in_rs1,
  input  reg_idx_t            in_rs2,
  input  reg_idx_t            in_rd,
  input  logic [WIDTH-1:0]    in_imm,
  input  logic                in_use_imm,
  input  logic [ALU_OP_W-1:0] in_op,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [WIDTH-1:0]    out_a,
  output logic [WIDTH-1:0]    out_b,
  output logic [ALU_OP_W-1:0] out_op,
  output reg_idx_t            out_rd,
  input  logic                wb_en,
  input  reg_idx_t            wb_rd,
  input  logic [WIDTH-1:0]    wb_data
);

  out_state_e       state, state_nxt;
  logic [NREGS-1:0] busy, busy_nxt;
  logic [WIDTH-1:0] rdata1, rdata2;
  logic             hazard;
  logic             in_fire;
  logic             out_fire;

  alu_regfile #(
    .WIDTH (WIDTH),
    .NREGS (NREGS)
  ) u_regfile (
    .clk    (clk),
    .rst    (rst),
    .raddr1 (in_rs1),
    .raddr2 (in_rs2),
    .rdata1 (rdata1),
    .rdata2 (rdata2),
    .we     (wb_en),
    .waddr  (wb_rd),
    .wdata  (wb_data)
  );

  always_comb begin
    hazard = src_hazard(busy[in_rs1], in_rs1, wb_en, wb_rd)
          || (!in_use_imm && src_hazard(busy[in_rs2], in_rs2, wb_en, wb_rd));
  end

  assign out_valid = (state == OUT_FULL);
  assign in_ready  = (!out_valid || out_ready) && !hazard;
  assign in_fire   = in_valid && in_ready;
  assign out_fire  = out_valid && out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= OUT_EMPTY;
    end else begin
      state <= state_nxt;
    end
  end

  // An accepted instruction always refills the register, even while draining the old one.
  always_comb begin
    state_nxt = state;
    case (state)
      OUT_EMPTY: if (in_fire) state_nxt = OUT_FULL;
      OUT_FULL:  if (out_fire && !in_fire) state_nxt = OUT_EMPTY;
      default:   state_nxt = OUT_EMPTY;
    endcase
  end

  // Clear is applied before set so a same-cycle issue to the written-back index stays busy.
  always_comb begin
    busy_nxt = busy;
    if (wb_en) begin
      busy_nxt[wb_rd] = 1'b0;
    end
    if (in_fire && (in_rd != '0)) begin
      busy_nxt[in_rd] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy <= '0;
    end else begin
      busy <= busy_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_a  <= '0;
      out_b  <= '0;
      out_op <= '0;
      out_rd <= '0;
    end else if (in_fire) begin
      out_a  <= rdata1;
      out_b  <= in_use_imm ? in_imm : rdata2;
      out_op <= in_op;
      out_rd <= in_rd;
    end
  end

endmodule

// File: tb/tb_alu_issue.sv
// Self-checking bench for alu_issue: a reference register/busy model pushes expected
// issues into a scoreboard that a negedge monitor pops when the ALU takes them.
module tb_alu_issue;

  typedef struct {
    logic [63:0] a;
    logic [63:0] b;
    logic [3:0]  op;
    logic [4:0]  rd;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_rs1, in_rs2, in_rd;
  logic [63:0] in_imm;
  logic        in_use_imm;
  logic [3:0]  in_op;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_a, out_b;
  logic [3:0]  out_op;
  logic [4:0]  out_rd;
  logic        wb_en;
  logic [4:0]  wb_rd;
  logic [63:0] wb_data;

  int          checks = 0;
  int          errors = 0;

  exp_t        sb[$];
  exp_t        mon_e;
  logic [63:0] m_regs [32];
  logic [31:0] m_busy;
  logic        m_out_valid;

  alu_issue #(
    .WIDTH (64),
    .NREGS (32)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_rs1     (in_rs1),
    .in_rs2     (in_rs2),
    .in_rd      (in_rd),
    .in_imm     (in_imm),
    .in_use_imm (in_use_imm),
    .in_op      (in_op),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_a      (out_a),
    .out_b      (out_b),
    .out_op     (out_op),
    .out_rd     (out_rd),
    .wb_en      (wb_en),
    .wb_rd      (wb_rd),
    .wb_data    (wb_data)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_regs[i] = '0;
    m_busy      = '0;
    m_out_valid = 1'b0;
    sb.delete();
  endtask

  function automatic logic [63:0] model_read(input logic [4:0] idx);
    if (idx == 5'd0) return 64'd0;
    if (wb_en && wb_rd == idx) return wb_data;
    return m_regs[idx];
  endfunction

  function automatic logic model_ready();
    logic h1, h2;
    h1 = m_busy[in_rs1] && in_rs1 != 5'd0 && !(wb_en && wb_rd == in_rs1);
    h2 = !in_use_imm && m_busy[in_rs2] && in_rs2 != 5'd0 && !(wb_en && wb_rd == in_rs2);
    return (!m_out_valid || out_ready) && !(h1 || h2);
  endfunction

  // One clock: predict transfers from the inputs currently driven, then advance the model.
  task automatic tick();
    logic fire_in, fire_out;
    exp_t e;
    if (rst) begin
      @(posedge clk);
      #1;
      return;
    end
    fire_in  = in_valid && model_ready();
    fire_out = m_out_valid && out_ready;
    e.a  = model_read(in_rs1);
    e.b  = in_use_imm ? in_imm : model_read(in_rs2);
    e.op = in_op;
    e.rd = in_rd;
    @(posedge clk);
    if (fire_in) sb.push_back(e);
    if (wb_en && wb_rd != 5'd0) m_regs[wb_rd] = wb_data;
    if (wb_en) m_busy[wb_rd] = 1'b0;
    if (fire_in && e.rd != 5'd0) m_busy[e.rd] = 1'b1;
    m_out_valid = fire_in ? 1'b1 : (fire_out ? 1'b0 : m_out_valid);
    #1;
  endtask

  task automatic set_in(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                        input logic [63:0] imm, input logic use_imm, input logic [3:0] op);
    in_valid   = 1'b1;
    in_rs1     = rs1;
    in_rs2     = rs2;
    in_rd      = rd;
    in_imm     = imm;
    in_use_imm = use_imm;
    in_op      = op;
    #1;
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    checks++;
    if (out_valid !== m_out_valid) begin
      errors++;
      $display("FAIL out_valid_track: got %b expected %b at %0t", out_valid, m_out_valid, $time);
    end
    if (out_valid === 1'b1 && out_ready === 1'b1) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected: got issue op=%h rd=%0d expected none at %0t", out_op, out_rd, $time);
      end else begin
        mon_e = sb.pop_front();
        if (out_a !== mon_e.a || out_b !== mon_e.b || out_op !== mon_e.op || out_rd !== mon_e.rd) begin
          errors++;
          $display("FAIL sb_issue: got a=%h b=%h op=%h rd=%0d expected a=%h b=%h op=%h rd=%0d",
                   out_a, out_b, out_op, out_rd, mon_e.a, mon_e.b, mon_e.op, mon_e.rd);
        end
      end
    end
  end

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    model_reset();
    #3;
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", out_valid); end
    checks++;
    if (out_a !== 64'd0 || out_b !== 64'd0) begin
      errors++; $display("FAIL reset_ab: got a=%h b=%h expected 0", out_a, out_b);
    end
    checks++;
    if (out_op !== 4'd0 || out_rd !== 5'd0) begin
      errors++; $display("FAIL reset_op_rd: got op=%h rd=%0d expected 0", out_op, out_rd);
    end
    tick();
    tick();
    rst = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", in_ready); end
  endtask

  task automatic test_wb_read();
    wb_en = 1'b1; wb_rd = 5'd5; wb_data = 64'hffff_ffff_ffff_fff0;
    tick();
    wb_en = 1'b0;
    set_in(5'd5, 5'd0, 5'd0, 64'd0, 1'b0, 4'd8);
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL wbread_ready: got %b expected 1", in_ready); end
    tick();
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || out_a !== 64'hffff_ffff_ffff_fff0 || out_b !== 64'd0 || out_op !== 4'd8) begin
      errors++;
      $display("FAIL wbread_issue: got v=%b a=%h b=%h op=%h expected v=1 a=fffffffffffffff0 b=0 op=8",
               out_valid, out_a, out_b, out_op);
    end
    tick();
  endtask

  task automatic test_hazard();
    out_ready = 1'b1;
    set_in(5'd1, 5'd0, 5'd7, 64'd0, 1'b0, 4'd0);
    tick();
    set_in(5'd7, 5'd0, 5'd0, 64'd0, 1'b0, 4'd1);
    for (int c = 0; c < 2; c++) begin
      checks++;
      if (in_ready !== 1'b0) begin errors++; $display("FAIL hazard_stall: got %b expected 0", in_ready); end
      tick();
    end
    wb_en = 1'b1; wb_rd = 5'd7; wb_data = 64'h10;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL hazard_wb_ready: got %b expected 1", in_ready); end
    tick();
    wb_en = 1'b0; in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || out_a !== 64'h10) begin
      errors++; $display("FAIL hazard_bypass: got v=%b a=%h expected v=1 a=10", out_valid, out_a);
    end
    tick();
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    set_in(5'd5, 5'd0, 5'd0, 64'd0, 1'b0, 4'd3);
    tick();
    set_in(5'd0, 5'd5, 5'd9, 64'd0, 1'b0, 4'd4);
    for (int c = 0; c < 3; c++) begin
      checks++;
      if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_ready: got %b expected 0", in_ready); end
      checks++;
      if (out_valid !== 1'b1 || out_a !== 64'hffff_ffff_ffff_fff0 || out_op !== 4'd3) begin
        errors++; $display("FAIL bp_hold: got v=%b a=%h op=%h expected v=1 a=fffffffffffffff0 op=3",
                           out_valid, out_a, out_op);
      end
      tick();
    end
    out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_release_ready: got %b expected 1", in_ready); end
    tick();
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || out_op !== 4'd4 || out_b !== 64'hffff_ffff_ffff_fff0 || out_rd !== 5'd9) begin
      errors++; $display("FAIL bp_no_bubble: got v=%b op=%h b=%h rd=%0d expected v=1 op=4 b=fffffffffffffff0 rd=9",
                         out_valid, out_op, out_b, out_rd);
    end
    tick();
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_drain: got %b expected 0", out_valid); end
    wb_en = 1'b1; wb_rd = 5'd9; wb_data = 64'h99;
    tick();
    wb_en = 1'b0;
  endtask

  task automatic test_x0_imm();
    wb_en = 1'b1; wb_rd = 5'd0; wb_data = 64'h1234;
    tick();
    wb_data = 64'h5678;
    set_in(5'd0, 5'd0, 5'd0, 64'd0, 1'b0, 4'd2);
    tick();
    wb_en = 1'b0; in_valid = 1'b0;
    checks++;
    if (out_a !== 64'd0 || out_b !== 64'd0) begin
      errors++; $display("FAIL x0_read: got a=%h b=%h expected 0", out_a, out_b);
    end
    tick();
    set_in(5'd1, 5'd0, 5'd12, 64'd0, 1'b0, 4'd0);
    tick();
    set_in(5'd0, 5'd12, 5'd0, 64'h7ff, 1'b0, 4'd5);
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL rs2_busy_stall: got %b expected 0", in_ready); end
    in_use_imm = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL imm_ready: got %b expected 1", in_ready); end
    tick();
    in_valid = 1'b0;
    checks++;
    if (out_b !== 64'h7ff) begin errors++; $display("FAIL imm_b: got %h expected 7ff", out_b); end
    wb_en = 1'b1; wb_rd = 5'd12; wb_data = 64'hc;
    tick();
    wb_en = 1'b0;
  endtask

  task automatic test_set_wins_reset();
    out_ready = 1'b1;
    set_in(5'd0, 5'd0, 5'd3, 64'd0, 1'b0, 4'd1);
    wb_en = 1'b1; wb_rd = 5'd3; wb_data = 64'h33;
    tick();
    wb_en = 1'b0;
    set_in(5'd3, 5'd0, 5'd0, 64'd0, 1'b0, 4'd1);
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL set_wins: got in_ready %b expected 0", in_ready); end
    out_ready = 1'b0;
    tick();
    rst = 1'b1;
    model_reset();
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_a !== 64'd0 || out_rd !== 5'd0) begin
      errors++; $display("FAIL rst_async: got v=%b a=%h rd=%0d expected 0", out_valid, out_a, out_rd);
    end
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_busy_clear: got in_ready %b expected 1", in_ready); end
    in_valid = 1'b0;
    tick();
    rst = 1'b0;
    out_ready = 1'b1;
    set_in(5'd5, 5'd7, 5'd0, 64'd0, 1'b0, 4'd0);
    tick();
    in_valid = 1'b0;
    checks++;
    if (out_a !== 64'd0 || out_b !== 64'd0) begin
      errors++; $display("FAIL rst_regs_zero: got a=%h b=%h expected 0", out_a, out_b);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    for (int n = 0; n < 200; n++) begin
      in_valid   = ($urandom_range(0, 9) < 7);
      in_rs1     = 5'($urandom_range(0, 7));
      in_rs2     = 5'($urandom_range(0, 7));
      in_rd      = 5'($urandom_range(0, 7));
      in_imm     = {$urandom, $urandom};
      in_use_imm = ($urandom_range(0, 3) == 0);
      in_op      = 4'($urandom_range(0, 15));
      out_ready  = ($urandom_range(0, 9) < 7);
      wb_en      = ($urandom_range(0, 1) == 1);
      wb_rd      = 5'($urandom_range(0, 7));
      wb_data    = {$urandom, $urandom};
      #1;
      checks++;
      if (in_ready !== model_ready()) begin
        errors++; $display("FAIL b2b_ready: got %b expected %b at %0t", in_ready, model_ready(), $time);
      end
      tick();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int r = 1; r < 8; r++) begin
      wb_en = 1'b1; wb_rd = 5'(r); wb_data = {$urandom, $urandom};
      tick();
    end
    wb_en = 1'b0;
    tick();
    checks++;
    if (sb.size() != 0 || out_valid !== 1'b0) begin
      errors++; $display("FAIL b2b_drain: got pending=%0d v=%b expected 0 0", sb.size(), out_valid);
    end
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0; in_rs1 = '0; in_rs2 = '0; in_rd = '0; in_imm = '0; in_use_imm = 1'b0; in_op = '0;
    out_ready = 1'b1;
    wb_en = 1'b0; wb_rd = '0; wb_data = '0;
    test_reset();
    test_wb_read();
    test_hazard();
    test_backpressure();
    test_x0_imm();
    test_set_wins_reset();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no completion expected finish before 200000");
    $fatal(1, "timeout");
  end

endmodule
